// File: rtl/loop_issue_queue.sv
// loop_issue_queue: in-order issue queue between the loop-detect FSM and decode.
// Merges the fetch stream and the micro-op cache replay stream into one circular
// buffer of {instr, pc}, presents the head to decode over valid/ready, and on a
// loop flush drains the queue and emits a one-cycle fetch redirect.
//
// Ports:
//   clk, reset (async, active-low)
//   fetch_valid/fetch_instr/fetch_pc/fetch_ready : fetch stream in
//   block_signal, buf_instr, loop_len, loop_pc    : replay control from loop FSM
//   flush, new_pc                                 : flush request / recovery PC
//   buf_hold, overrun                             : replay backpressure / sticky drop flag
//   dec_valid/dec_instr/dec_pc/dec_ready          : decode handshake out
//   redirect_valid, redirect_pc                   : one-cycle fetch redirect
//
// Optional build macro LOOP_ISSUE_STATS_EN adds replay_count (replay entries
// pushed) and flush_count (redirects issued), both saturating.
module loop_issue_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] fetch_pc,
  output logic        fetch_ready,
  input  logic        block_signal,
  input  logic [31:0] buf_instr,
  input  logic [5:0]  loop_len,
  input  logic [31:0] loop_pc,
  input  logic        flush,
  input  logic [31:0] new_pc,
  output logic        buf_hold,
  output logic        overrun,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        dec_ready,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
`ifdef LOOP_ISSUE_STATS_EN
  ,
  output logic [31:0] replay_count,
  output logic [15:0] flush_count
`endif
);

  localparam logic [PTR_W:0] FullCnt = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {StFetch, StReplay, StFlush} state_e;

  state_e state_q, state_d;

  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      replay_pc_q;
  logic [5:0]       replay_idx_q;
  logic             overrun_q;

  logic full, head_ok, pop, room, fetch_push, replay_slot, replay_push, replay_drop;
  logic push, clear, enter_replay;

  assign full         = (count_q == FullCnt);
  // Head is hidden during the flush cycle and while the queue is being cleared.
  assign head_ok      = (count_q != '0) && !flush && (state_q != StFlush);
  assign pop          = head_ok && dec_ready;
  // A full queue can still take a push when the head leaves in the same cycle.
  assign room         = !full || pop;
  assign enter_replay = (state_q == StFetch) && !flush && block_signal;
  assign fetch_push   = (state_q == StFetch) && !flush && !block_signal && fetch_valid && room;
  // The cache delivers one entry every replay cycle whether or not we can take it.
  assign replay_slot  = (state_q == StReplay) && !flush;
  assign replay_push  = replay_slot && room;
  assign replay_drop  = replay_slot && !room;
  assign push         = fetch_push || replay_push;
  assign clear        = flush || (state_q == StFlush);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StFetch;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides every other transition
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StFlush;
    end else begin
      unique case (state_q)
        StFetch:  if (block_signal)  state_d = StReplay;
        StReplay: if (!block_signal) state_d = StFetch;
        StFlush:  state_d = StFetch;
        default:  state_d = StFetch;
      endcase
    end
  end

  // Outputs; data is zeroed when not valid so reset leaves every output at 0
  always_comb begin
    dec_valid      = head_ok;
    dec_instr      = head_ok ? instr_mem[rd_ptr_q] : 32'd0;
    dec_pc         = head_ok ? pc_mem[rd_ptr_q] : 32'd0;
    fetch_ready    = reset && (state_q == StFetch) && !flush && !block_signal && room;
    buf_hold       = (state_q == StReplay) && full;
    overrun        = overrun_q;
    redirect_valid = (state_q == StFlush) && !flush;
    redirect_pc    = redirect_valid ? new_pc : 32'd0;
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through head_ok
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= (state_q == StReplay) ? buf_instr : fetch_instr;
      pc_mem[wr_ptr_q]    <= (state_q == StReplay) ? replay_pc_q : fetch_pc;
    end
  end

  // Replay PC/index track the cache read pointer, advancing even on a drop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      replay_pc_q  <= '0;
      replay_idx_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      if (enter_replay) begin
        replay_pc_q  <= loop_pc;
        replay_idx_q <= '0;
      end else if (replay_slot) begin
        if (replay_idx_q == loop_len) begin
          replay_pc_q  <= loop_pc;
          replay_idx_q <= '0;
        end else begin
          replay_pc_q  <= replay_pc_q + 32'd4;
          replay_idx_q <= replay_idx_q + 6'd1;
        end
      end
      if (replay_drop) overrun_q <= 1'b1;
    end
  end

`ifdef LOOP_ISSUE_STATS_EN
  logic [31:0] replay_count_q;
  logic [15:0] flush_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      replay_count_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (replay_push && (replay_count_q != '1)) replay_count_q <= replay_count_q + 32'd1;
      if (redirect_valid && (flush_count_q != '1)) flush_count_q <= flush_count_q + 16'd1;
    end
  end

  assign replay_count = replay_count_q;
  assign flush_count  = flush_count_q;
`endif

endmodule
